// File: rtl/accumulator_8bit.sv
// accumulator_8bit: sums NUM_SAMPLES bytes through an external 8-bit adder.
// Optional build macro ACCUMULATOR_SATURATE_EN clamps the total at 8'hFF.
module accumulator_8bit #(
    parameter int NUM_SAMPLES = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_carry_in,
    input  logic [7:0] add_sum,
    input  logic       add_overflow,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_overflow,
    input  logic       out_ready
);

    localparam int CW = $clog2(NUM_SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t        state;
    logic [7:0]    acc;
    logic [CW-1:0] cnt;
    logic          ovf;

    logic          accept;
    logic [CW-1:0] cnt_nxt;
    logic          last;
    logic [7:0]    acc_nxt;

    assign in_ready = (state != DONE) && !clear;
    assign accept   = in_valid && in_ready;
    assign cnt_nxt  = cnt + CW'(1);
    assign last     = (cnt_nxt == CW'(NUM_SAMPLES));

`ifdef ACCUMULATOR_SATURATE_EN
    // Once any carry-out is seen the total is pinned until consumed.
    assign acc_nxt = (add_overflow || ovf) ? 8'hFF : add_sum;
`else
    assign acc_nxt = add_sum;
`endif

    assign add_a        = acc;
    assign add_b        = in_data;
    assign add_carry_in = 1'b0;

    assign out_valid    = (state == DONE);
    assign out_data     = acc;
    assign out_overflow = ovf;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= IDLE;
            acc   <= 8'd0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear || (state == DONE && out_ready)) begin
            state <= IDLE;
            acc   <= 8'd0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf | add_overflow;
            state <= last ? DONE : ACCUM;
        end
    end

endmodule

// File: tb/tb_accumulator_8bit.sv
// tb_accumulator_8bit: directed and random checks of accumulator_8bit
// against a sum-of-samples reference model, with a behavioural adder.
`timescale 1ns/1ps
module tb_accumulator_8bit;

    logic       clk = 1'b0;
    logic       n_rst;

    logic       clear, in_valid, in_ready, out_ready;
    logic [7:0] in_data, add_a, add_b, add_sum, out_data;
    logic       add_carry_in, add_overflow, out_valid, out_overflow;

    logic       clear1, in_valid1, in_ready1, out_ready1;
    logic [7:0] in_data1, add_a1, add_b1, add_sum1, out_data1;
    logic       add_carry_in1, add_overflow1, out_valid1, out_overflow1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External ripple-carry adder, modelled behaviourally.
    assign {add_overflow, add_sum}   = {1'b0, add_a} + {1'b0, add_b}
                                       + {8'd0, add_carry_in};
    assign {add_overflow1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1}
                                       + {8'd0, add_carry_in1};

    accumulator_8bit #(.NUM_SAMPLES(4)) dut (
        .clk(clk), .n_rst(n_rst), .clear(clear),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_carry_in(add_carry_in),
        .add_sum(add_sum), .add_overflow(add_overflow),
        .out_valid(out_valid), .out_data(out_data),
        .out_overflow(out_overflow), .out_ready(out_ready)
    );

    accumulator_8bit #(.NUM_SAMPLES(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .clear(clear1),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .add_a(add_a1), .add_b(add_b1), .add_carry_in(add_carry_in1),
        .add_sum(add_sum1), .add_overflow(add_overflow1),
        .out_valid(out_valid1), .out_data(out_data1),
        .out_overflow(out_overflow1), .out_ready(out_ready1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the total of the first k samples as the block reports it.
    function automatic logic [8:0] model(input logic [7:0] s[$], input int k);
        int  sum = 0;
        bit  big;
        logic [7:0] d;
        for (int i = 0; i < k; i++) sum += int'(s[i]);
        big = (sum > 255);
        d   = 8'(sum % 256);
`ifdef ACCUMULATOR_SATURATE_EN
        if (big) d = 8'hFF;
`endif
        return {big, d};
    endfunction

    // Feed one full result to dut, optionally with gaps and a stalled sink.
    task automatic run(input string tag, input logic [7:0] s[$],
                       input int hold, input bit gaps);
        logic [8:0] m;
        out_ready = (hold == 0);
        for (int i = 0; i < s.size(); i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = s[i];
            #1;
            chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
            tick();
            m = model(s, i + 1);
            chk({tag, " add_a"}, 32'(add_a), 32'(m[7:0]));
        end
        in_valid = 1'b0;
        m = model(s, s.size());
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " out_data"}, 32'(out_data), 32'(m[7:0]));
        chk({tag, " out_ovf"}, 32'(out_overflow), 32'(m[8]));
        chk({tag, " busy"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
            chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold_data"}, 32'(out_data), 32'(m[7:0]));
            chk({tag, " hold_ovf"}, 32'(out_overflow), 32'(m[8]));
            chk({tag, " hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " handoff_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " handoff_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, " handoff_acc"}, 32'(add_a), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [8:0] m;
        n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        out_ready = 1'b0;
        clear1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'd0; out_ready1 = 1'b0;
        tick();
        tick();
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_data", 32'(out_data), 32'd0);
        chk("rst out_ovf", 32'(out_overflow), 32'd0);
        chk("rst add_a", 32'(add_a), 32'd0);
        chk("rst carry_in", 32'(add_carry_in), 32'd0);
        chk("rst1 out_valid", 32'(out_valid1), 32'd0);
        n_rst = 1'b1;

        q = '{8'd10, 8'd20, 8'd30, 8'd40};
        run("b2b", q, 0, 1'b0);
        q = '{8'd200, 8'd100, 8'd1, 8'd1};
        run("wrap", q, 0, 1'b0);
        q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run("stall", q, 5, 1'b0);

        // Abort after two samples while a third is presented.
        in_valid = 1'b1; in_data = 8'd5; tick();
        in_data = 8'd7; tick();
        chk("clr pre acc", 32'(add_a), 32'd12);
        in_data = 8'd9; clear = 1'b1;
        #1;
        chk("clr in_ready", 32'(in_ready), 32'd0);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr acc", 32'(add_a), 32'd0);
        chk("clr out_valid", 32'(out_valid), 32'd0);
        q = '{8'd1, 8'd2, 8'd3, 8'd4};
        run("post_clr", q, 0, 1'b0);

        // Reset in the middle of a result with the sticky flag set.
        in_valid = 1'b1; in_data = 8'd200; tick();
        in_data = 8'd106; tick();
        in_valid = 1'b0;
        m = model('{8'd200, 8'd106}, 2);
        chk("mid acc", 32'(add_a), 32'(m[7:0]));
        n_rst = 1'b0;
        #2;
        chk("rst noedge acc", 32'(add_a), 32'(m[7:0]));
        tick();
        chk("rst mid acc", 32'(add_a), 32'd0);
        chk("rst mid rdy", 32'(in_ready), 32'd1);
        chk("rst mid valid", 32'(out_valid), 32'd0);
        n_rst = 1'b1;
        q = '{8'd1, 8'd2, 8'd3, 8'd4};
        run("post_rst", q, 0, 1'b0);

        // Discard a pending result with clear.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'd90; tick();
        end
        in_valid = 1'b0;
        chk("done clr pre", 32'(out_valid), 32'd1);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("done clr valid", 32'(out_valid), 32'd0);
        chk("done clr acc", 32'(add_a), 32'd0);
        chk("done clr ovf", 32'(out_overflow), 32'd0);

        for (int r = 0; r < 12; r++) begin
            q = {};
            for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
            run("rand", q, int'($urandom_range(0, 3)), 1'b1);
        end

        // Single-sample configuration.
        in_valid1 = 1'b1; in_data1 = 8'd255; out_ready1 = 1'b0;
        tick();
        in_valid1 = 1'b0;
        chk("n1 valid", 32'(out_valid1), 32'd1);
        chk("n1 data", 32'(out_data1), 32'd255);
        chk("n1 ovf", 32'(out_overflow1), 32'd0);
        chk("n1 busy", 32'(in_ready1), 32'd0);
        out_ready1 = 1'b1; tick();
        chk("n1 handoff", 32'(out_valid1), 32'd0);
        for (int r = 0; r < 4; r++) begin
            in_valid1 = 1'b1; in_data1 = 8'($urandom); tick();
            chk("n1 rand valid", 32'(out_valid1), 32'd1);
            chk("n1 rand data", 32'(out_data1), 32'(in_data1));
            in_valid1 = 1'b0; tick();
            chk("n1 rand idle", 32'(out_valid1), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accumulator_8bit.md
# accumulator_8bit

Sequential accumulation stage wrapped around the 8-bit ripple-carry adder. It accepts a stream of unsigned bytes over a valid/ready handshake and drives the adder's operand ports with the running total and the incoming byte. It registers the adder's sum and carry-out, and after NUM_SAMPLES bytes presents the total, with a sticky overflow flag, on a valid/ready output.

## Interface
- NUM_SAMPLES, 4, number of bytes summed per result; legal range 1..255.
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- clear  input  1  synchronous abort; discards the partial total.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  8  unsigned sample.
- in_ready  output  1  block can accept a sample this cycle.
- add_a  output  8  adder operand a; always equals the accumulator register.
- add_b  output  8  adder operand b; always equals in_data.
- add_carry_in  output  1  adder carry-in; constant 0.
- add_sum  input  8  adder sum, combinational from add_a/add_b.
- add_overflow  input  1  adder carry-out.
- out_valid  output  1  result is available.
- out_data  output  8  accumulated total.
- out_overflow  output  1  at least one carry-out occurred during this result.
- out_ready  input  1  downstream accepts the result.

## Operation
- State machine: IDLE, ACCUM, DONE.
- Registers:
  - acc[7:0]
  - cnt, $clog2(NUM_SAMPLES+1) bits
  - ovf (sticky)
  - state
- Reset (n_rst=0 at a clock edge):
  - state=IDLE, acc=0, cnt=0, ovf=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_overflow=0, add_a=0, add_carry_in=0.
- in_ready = (state != DONE) && !clear.
- Accept = in_valid && in_ready. On accept:
  - acc <= add_sum
  - cnt <= cnt+1
  - ovf <= ovf | add_overflow
- State transitions:
  - IDLE -> ACCUM on accept when NUM_SAMPLES > 1.
  - IDLE -> DONE on accept when NUM_SAMPLES == 1.
  - ACCUM -> DONE on the accept that makes cnt == NUM_SAMPLES.
  - DONE: out_valid=1, out_data=acc, out_overflow=ovf. All are held stable until out_ready=1.
  - DONE && out_ready -> IDLE, with acc=0, cnt=0, ovf=0.
- clear=1:
  - From IDLE or ACCUM: next state is IDLE, acc/cnt/ovf zeroed, and any sample presented that cycle is dropped.
  - In DONE: the pending result is discarded.
- Priority: n_rst > clear > out handshake > input accept.
- Arithmetic is unsigned modulo 256. Without the configuration feature, acc wraps on carry-out.
- in_valid in DONE is ignored. The source must hold in_valid/in_data until in_ready is sampled high.

## Timing
- Throughput is one sample per cycle while in IDLE or ACCUM.
- The accumulator update is visible on add_a one cycle after the accepting edge.
- Latency: out_valid rises in the cycle after the edge that accepts the final sample.
- Result hand-off: out_valid falls and in_ready rises in the cycle after the edge where out_valid && out_ready. The next result's first sample can be accepted in that same cycle. The minimum period is NUM_SAMPLES+1 cycles per result.
- The adder path (add_a -> add_sum) is combinational and must settle within one clock period.

## Configuration
- ACCUMULATOR_SATURATE_EN defined:
  - On any accept where add_overflow=1, or while ovf=1, acc <= 8'hFF and holds 8'hFF until the result is consumed.
  - out_overflow behaves identically to the non-saturating build.
- ACCUMULATOR_SATURATE_EN undefined: acc <= add_sum always (wrapping).

## Test plan
- Back-to-back samples 10, 20, 30, 40 with out_ready=1 and NUM_SAMPLES=4 -> out_valid for one cycle, out_data=100, out_overflow=0; in_ready=1 again the next cycle.
- Samples 200, 100, 1, 1 -> out_overflow=1. out_data=46 without the macro (wrapped at 300 -> 44). out_data=255 with ACCUMULATOR_SATURATE_EN.
- Full result pending with out_ready held 0 for 5 cycles -> out_valid/out_data/out_overflow stable, in_ready=0, extra in_valid ignored. out_ready=1 -> IDLE next cycle.
- clear asserted after 2 samples (5, 7), concurrent with a third in_valid -> third sample dropped, acc=0. Samples 1, 2, 3, 4 then give out_data=10.
- n_rst=0 mid-ACCUM (acc=50, ovf=1) -> next edge: acc=0, ovf=0, state=IDLE, out_valid=0, in_ready=1. Reset with no clock edge leaves the state unchanged.
- NUM_SAMPLES=1, sample 255 -> out_valid in the following cycle, out_data=255, out_overflow=0.
